// File: rtl/output_scaler_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : output_scaler_ctrl
// Description : Job controller and two-stage pipeline wrapped around an
//               external combinational output scaler. Holds a per-channel
//               {scale, shift} table, accepts a job of num_beats_i input
//               beats, presents each beat's accumulator vector plus its
//               channel's table entry to the scaler, and streams the
//               quantized result out with a last-beat marker.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, nrst                 : clock (rising edge), async active-low reset
//   cfg_we_i/addr/scale/shift : table write (accepted in IDLE only)
//   cfg_err_o                 : one-cycle pulse when a write is rejected
//   start_i, num_beats_i      : job start and length (latched at start)
//   busy_o, done_o            : job active / one-cycle completion pulse
//   in_valid_i/in_ready_o     : input beat handshake
//   in_ch_i, in_wx_i          : beat channel index and accumulator vector
//   sc_wx_o/scale_o/shift_o   : operands for the external scaler
//   sc_y_i                    : combinational scaler result
//   out_valid_o/out_ready_i   : output beat handshake
//   out_y_o, out_last_o       : quantized vector and final-beat flag
// ============================================================================
module output_scaler_ctrl #(
    parameter int numElements    = 4,
    parameter int elementWidth   = 20,
    parameter int outputWidth    = 8,
    parameter int fixedPointBits = 16,
    parameter int shiftBits      = 16,
    parameter int numChannels    = 16,
    parameter int countWidth     = 16
) (
    input  logic                                clk,
    input  logic                                nrst,
    // configuration
    input  logic                                cfg_we_i,
    input  logic [$clog2(numChannels)-1:0]      cfg_addr_i,
    input  logic [fixedPointBits-1:0]           cfg_scale_i,
    input  logic [shiftBits-1:0]                cfg_shift_i,
    output logic                                cfg_err_o,
    // job control
    input  logic                                start_i,
    input  logic [countWidth-1:0]               num_beats_i,
    output logic                                busy_o,
    output logic                                done_o,
    // input stream
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [$clog2(numChannels)-1:0]      in_ch_i,
    input  logic [numElements*elementWidth-1:0] in_wx_i,
    // external scaler
    output logic [numElements*elementWidth-1:0] sc_wx_o,
    output logic [fixedPointBits-1:0]           sc_scale_o,
    output logic [shiftBits-1:0]                sc_shift_o,
    input  logic [numElements*outputWidth-1:0]  sc_y_i,
    // output stream
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [numElements*outputWidth-1:0]  out_y_o,
    output logic                                out_last_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]                          r_state;
    logic [1:0]                          w_state_nxt;

    logic [fixedPointBits-1:0]           r_scale_tbl [numChannels];
    logic [shiftBits-1:0]                r_shift_tbl [numChannels];
    logic                                r_cfg_err;

    logic [countWidth-1:0]               r_num_beats;
    logic [countWidth-1:0]               r_beat_cnt;

    logic                                r_s1_valid;
    logic [numElements*elementWidth-1:0] r_s1_wx;
    logic [fixedPointBits-1:0]           r_s1_scale;
    logic [shiftBits-1:0]                r_s1_shift;
    logic                                r_s1_last;

    logic                                r_s2_valid;
    logic [numElements*outputWidth-1:0]  r_s2_y;
    logic                                r_s2_last;

    logic                                w_in_ready;
    logic                                w_in_fire;
    logic                                w_s2_load;
    logic                                w_out_fire;
    logic                                w_last_in;

    // Stage 2 takes the stage-1 beat whenever it is empty or emptying now,
    // which is what gives one beat per cycle with out_ready_i held high.
    assign w_s2_load  = r_s1_valid & (~r_s2_valid | out_ready_i);
    assign w_out_fire = r_s2_valid & out_ready_i;
    assign w_in_fire  = in_valid_i & w_in_ready;
    // Only evaluated in RUN, where r_num_beats is known to be non-zero.
    assign w_last_in  = (r_beat_cnt == (r_num_beats - countWidth'(1)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (num_beats_i == '0) ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (w_in_fire && w_last_in) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_out_fire && r_s2_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o     = (r_state == c_RUN) || (r_state == c_DRAIN);
        done_o     = (r_state == c_DONE);
        w_in_ready = (r_state == c_RUN) && (!r_s1_valid || w_s2_load);
    end

    assign in_ready_o = w_in_ready;
    assign cfg_err_o  = r_cfg_err;

    // ------------------------------------------------------------------
    // Channel table. Writes land only while idle so a running job always
    // sees a consistent table; rejected writes raise a registered pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < numChannels; i++) begin
                r_scale_tbl[i] <= '0;
                r_shift_tbl[i] <= '0;
            end
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we_i && (r_state != c_IDLE);
            if (cfg_we_i && (r_state == c_IDLE)) begin
                r_scale_tbl[cfg_addr_i] <= cfg_scale_i;
                r_shift_tbl[cfg_addr_i] <= cfg_shift_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Job length latch and accepted-beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_num_beats <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if ((r_state == c_IDLE) && start_i) begin
                r_num_beats <= num_beats_i;
                r_beat_cnt  <= '0;
            end else if (w_in_fire) begin
                r_beat_cnt  <= r_beat_cnt + countWidth'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: captured beat plus a private copy of its table entry, so
    // the scaler operands never depend on the live table.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s1_valid <= 1'b0;
            r_s1_wx    <= '0;
            r_s1_scale <= '0;
            r_s1_shift <= '0;
            r_s1_last  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_wx    <= in_wx_i;
                r_s1_scale <= r_scale_tbl[in_ch_i];
                r_s1_shift <= r_shift_tbl[in_ch_i];
                r_s1_last  <= w_last_in;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign sc_wx_o    = r_s1_wx;
    assign sc_scale_o = r_s1_scale;
    assign sc_shift_o = r_s1_shift;

    // ------------------------------------------------------------------
    // Stage 2: registered scaler result, held while downstream stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_last  <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_y     <= sc_y_i;
                r_s2_last  <= r_s1_last;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign out_y_o     = r_s2_y;
    assign out_last_o  = r_s2_valid & r_s2_last;

endmodule
`default_nettype wire

// File: doc/output_scaler_ctrl.md
OUTPUT_SCALER_CTRL -- requirements
Module: output_scaler_ctrl

Interface
REQ-001 Parameters SHALL be as follows: numElements, default 4, vector lanes per beat; elementWidth, default 20, accumulator lane width; outputWidth, default 8, quantized lane width; fixedPointBits, default 16, scale width; shiftBits, default 16, shift width; numChannels, default 16, scale/shift table depth; countWidth, default 16, job length counter width.
REQ-002 The clock and reset SHALL be: clk  in  1  one clock, all logic on rising edge; nrst  in  1  reset, asynchronous, active-low.
REQ-003 Configuration ports SHALL be: cfg_we_i  in  1  table write strobe; cfg_addr_i  in  clog2(numChannels)  table index; cfg_scale_i  in  fixedPointBits  scale value; cfg_shift_i  in  shiftBits  shift value; cfg_err_o  out  1  write-rejected pulse.
REQ-004 Job ports SHALL be: start_i  in  1  job start pulse; num_beats_i  in  countWidth  beats in job; busy_o  out  1  job active; done_o  out  1  one-cycle job-complete pulse.
REQ-005 Input stream ports SHALL be: in_valid_i  in  1; in_ready_o  out  1; in_ch_i  in  clog2(numChannels)  table index for beat; in_wx_i  in  numElements*elementWidth  signed accumulator vector.
REQ-006 Scaler-drive ports SHALL be: sc_wx_o  out  numElements*elementWidth; sc_scale_o  out  fixedPointBits; sc_shift_o  out  shiftBits; sc_y_i  in  numElements*outputWidth  combinational result of the external scaler.
REQ-007 Output stream ports SHALL be: out_valid_o  out  1; out_ready_i  in  1; out_y_o  out  numElements*outputWidth; out_last_o  out  1  final beat of job.

Function
REQ-008 The block SHALL hold a numChannels-entry table of {scale, shift}, written on cfg_we_i only in IDLE; a write outside IDLE SHALL be dropped and SHALL pulse cfg_err_o for one cycle.
REQ-009 The FSM SHALL have states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i with num_beats_i>0; start_i with num_beats_i==0 SHALL go IDLE->DONE directly; start_i outside IDLE SHALL be ignored.
REQ-010 RUN->DRAIN SHALL occur on the cycle the num_beats_i-th input beat is accepted; DRAIN->DONE when the beat with out_last_o is accepted downstream; DONE->IDLE after exactly one cycle, with done_o high only in DONE.
REQ-011 busy_o SHALL be high in RUN and DRAIN only.
REQ-012 num_beats_i SHALL be latched at start; later changes SHALL have no effect on the running job.
REQ-013 Stage 1 SHALL register in_wx_i and the table entry for in_ch_i on input handshake (in_valid_i & in_ready_o); sc_wx_o, sc_scale_o, sc_shift_o SHALL be driven from stage-1 registers only.
REQ-014 Stage 2 SHALL register sc_y_i into out_y_o when stage 1 holds a beat and stage 2 is empty or being drained the same cycle; out_last_o SHALL travel with the last beat.
REQ-015 Latency SHALL be 2 cycles from input handshake to out_valid_o with out_ready_i held high; throughput SHALL be one beat per cycle sustained.
REQ-016 in_ready_o SHALL be high only in RUN and when stage 1 is empty or advancing the same cycle; it SHALL be low in IDLE, DRAIN, DONE.
REQ-017 Under out_ready_i low, out_valid_o and out_y_o SHALL hold stable until accepted; no beat SHALL be lost or duplicated.
REQ-018 A table write to an index SHALL not alter beats already captured in stage 1.
REQ-019 The beat counter SHALL count accepted input beats; no wrap-around SHALL occur within a job because the counter width equals countWidth.

Reset
REQ-020 On nrst low, state SHALL be IDLE, and busy_o, done_o, cfg_err_o, in_ready_o, out_valid_o, out_last_o SHALL be 0.
REQ-021 On nrst low, out_y_o, the sc_* outputs, the counter, and all table entries SHALL be 0.
REQ-022 Reset asserted mid-job SHALL discard all in-flight beats with no done_o.

Verification
REQ-023 A bench SHALL cover: table[3]={scale 0x8000, shift 1}, job of 4 beats on ch 3, out_ready_i=1 -> 4 outputs, each 2 cycles after its input, out_last_o on the 4th, done_o one cycle after the last accept.
REQ-024 A bench SHALL cover: job of 8 beats with out_ready_i toggling 1/0 each cycle -> 8 outputs in order, out_y_o stable while stalled, in_ready_o deasserting under backpressure.
REQ-025 A bench SHALL cover: cfg_we_i during RUN -> cfg_err_o pulse, table unchanged on readback via a subsequent job.
REQ-026 A bench SHALL cover: start_i with num_beats_i=0 -> done_o 1 cycle later, no output beats, busy_o never high.
REQ-027 A bench SHALL cover: nrst pulsed after 2 of 5 beats -> all outputs 0, state IDLE, no done_o; a new 1-beat job then completes normally.
REQ-028 A bench SHALL cover: alternating ch 0/ch 1 with different scales at full rate -> each output matches its own channel's scale.
